// File: rtl/sdp_ram_pkg.sv
// Shared types for the simple dual-port byte-enable RAM: read-during-write policy and the
// state encoding of the post-reset clear sweep.
package sdp_ram_pkg;

   typedef enum logic {
      RDW_READ_FIRST,
      RDW_WRITE_FIRST
   } rdw_mode_e;

   typedef enum logic {
      IDLE,
      CLEAR
   } clr_state_e;

endpackage

// File: rtl/sdp_ram_clr_ctrl.sv
// Clear sequencer: after reset, sweeps every address once writing zero while holding busy.
module sdp_ram_clr_ctrl
   import sdp_ram_pkg::*;
#(
   parameter int unsigned WORDS      = 256,
   parameter bit          CLR_ON_RST = 1'b1,
   parameter int unsigned AW         = $clog2(WORDS)
) (
   input  logic          clk,
   input  logic          rst,
   output logic          busy,
   output logic          clr_we,
   output logic [AW-1:0] clr_addr
);

   localparam logic [AW-1:0] LastAddr = AW'(WORDS - 1);

   clr_state_e    state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == CLEAR) begin
         if (cnt_q == LastAddr) begin
            cnt_d   = '0;
            state_d = IDLE;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CLR_ON_RST ? CLEAR : IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Busy also covers the reset cycle itself so requests presented alongside rst are dropped.
   assign busy     = (state_q == CLEAR) || (CLR_ON_RST && rst);
   assign clr_we   = (state_q == CLEAR);
   assign clr_addr = cnt_q;

endmodule

// File: rtl/sdp_ram_be.sv
// Simple dual-port RAM with per-lane write enables, selectable read-during-write policy,
// optional output register and an optional zero-fill sweep after reset.
module sdp_ram_be
   import sdp_ram_pkg::*;
#(
   parameter int unsigned DW         = 32,
   parameter int unsigned BW         = 8,
   parameter int unsigned WORDS      = 256,
   parameter rdw_mode_e   RDW_MODE   = RDW_READ_FIRST,
   parameter bit          OUT_REG    = 1'b0,
   parameter bit          CLR_ON_RST = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [$clog2(WORDS)-1:0] addr_a,
   input  logic                     wr_a,
   input  logic [DW/BW-1:0]         be_a,
   input  logic [DW-1:0]            din_a,
   input  logic [$clog2(WORDS)-1:0] addr_b,
   input  logic                     rd_b,
   output logic [DW-1:0]            qout_b,
   output logic                     vld_b,
   output logic                     busy
);

   localparam int unsigned NB = DW / BW;
   localparam int unsigned AW = $clog2(WORDS);

   logic          clr_we;
   logic [AW-1:0] clr_addr;

   sdp_ram_clr_ctrl #(
      .WORDS      (WORDS),
      .CLR_ON_RST (CLR_ON_RST),
      .AW         (AW)
   ) u_clr_ctrl (
      .clk      (clk),
      .rst      (rst),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   logic [DW-1:0] mem_q [WORDS];
   logic [DW-1:0] lane_mask;
   logic [DW-1:0] wr_word;
   logic [DW-1:0] rd_word;
   logic          wr_fire;
   logic          rd_fire;

   assign wr_fire = wr_a & ~busy;
   assign rd_fire = rd_b & ~busy;

   always_comb begin
      lane_mask = '0;
      for (int i = 0; i < NB; i++) begin
         lane_mask[i*BW +: BW] = {BW{be_a[i]}};
      end
   end

   assign wr_word = (mem_q[addr_a] & ~lane_mask) | (din_a & lane_mask);

   // Write-first forwards the merged word so a colliding read sees this cycle's write.
   always_comb begin
      rd_word = mem_q[addr_b];
      if (RDW_MODE == RDW_WRITE_FIRST && wr_fire && addr_a == addr_b) begin
         rd_word = wr_word;
      end
   end

   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem_q[clr_addr] <= '0;
      end else if (wr_fire) begin
         mem_q[addr_a] <= wr_word;
      end
   end

   logic [DW-1:0] s1_data_q;
   logic          s1_vld_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_data_q <= '0;
         s1_vld_q  <= 1'b0;
      end else begin
         s1_vld_q <= rd_fire;
         if (rd_fire) begin
            s1_data_q <= rd_word;
         end
      end
   end

   if (OUT_REG) begin : g_out_reg
      logic [DW-1:0] s2_data_q;
      logic          s2_vld_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            s2_data_q <= '0;
            s2_vld_q  <= 1'b0;
         end else begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
               s2_data_q <= s1_data_q;
            end
         end
      end

      assign qout_b = s2_data_q;
      assign vld_b  = s2_vld_q;
   end else begin : g_no_out_reg
      assign qout_b = s1_data_q;
      assign vld_b  = s1_vld_q;
   end

endmodule

// File: tb/tb_sdp_ram_be.sv
// Scoreboard bench: two instances (read-first/no output reg, write-first/output reg) share
// stimulus; a word-array reference model predicts each read, a monitor checks every cycle.
module tb_sdp_ram_be;
   import sdp_ram_pkg::*;

   localparam int unsigned DW    = 32;
   localparam int unsigned BW    = 8;
   localparam int unsigned NB    = 4;
   localparam int unsigned WORDS = 16;
   localparam int unsigned AW    = 4;

   logic          clk;
   logic          rst;
   logic          wr_a;
   logic          rd_b;
   logic [AW-1:0] addr_a;
   logic [AW-1:0] addr_b;
   logic [NB-1:0] be_a;
   logic [DW-1:0] din_a;
   logic [DW-1:0] qout_rf, qout_wf;
   logic          vld_rf, vld_wf;
   logic          busy_rf, busy_wf;

   sdp_ram_be #(
      .DW (DW), .BW (BW), .WORDS (WORDS), .RDW_MODE (RDW_READ_FIRST),
      .OUT_REG (1'b0), .CLR_ON_RST (1'b1)
   ) dut_rf (
      .clk (clk), .rst (rst), .addr_a (addr_a), .wr_a (wr_a), .be_a (be_a), .din_a (din_a),
      .addr_b (addr_b), .rd_b (rd_b), .qout_b (qout_rf), .vld_b (vld_rf), .busy (busy_rf)
   );

   sdp_ram_be #(
      .DW (DW), .BW (BW), .WORDS (WORDS), .RDW_MODE (RDW_WRITE_FIRST),
      .OUT_REG (1'b1), .CLR_ON_RST (1'b1)
   ) dut_wf (
      .clk (clk), .rst (rst), .addr_a (addr_a), .wr_a (wr_a), .be_a (be_a), .din_a (din_a),
      .addr_b (addr_b), .rd_b (rd_b), .qout_b (qout_wf), .vld_b (vld_wf), .busy (busy_wf)
   );

   typedef struct {
      int            due;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          q_rf[$];
   exp_t          q_wf[$];
   logic [DW-1:0] model_mem [WORDS];
   logic [DW-1:0] last_rf, last_wf;
   bit            exp_busy;
   int            clr_rem;
   int            edge_n   = 0;
   bit            mon_en   = 0;
   int            n_checks = 0;
   int            n_pass   = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                           input logic [NB-1:0] be);
      logic [DW-1:0] r = old;
      for (int b = 0; b < NB; b++) if (be[b]) r[b*BW +: BW] = d[b*BW +: BW];
      return r;
   endfunction

   function automatic void chk(input bit ok, input string name, input logic [DW-1:0] act,
                               input logic [DW-1:0] exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s at edge %0d: got %h want %h", name, edge_n, act, exp);
   endfunction

   task automatic mon_one(input int which, input logic v, input logic [DW-1:0] q,
                          input logic b);
      string         tag;
      exp_t          e;
      bit            have;
      logic [DW-1:0] last;
      tag  = (which == 0) ? "rf" : "wf";
      have = (which == 0) ? (q_rf.size() > 0) : (q_wf.size() > 0);
      if (have) e = (which == 0) ? q_rf[0] : q_wf[0];
      last = (which == 0) ? last_rf : last_wf;
      chk(b === exp_busy, {tag, "_busy"}, DW'(b), DW'(exp_busy));
      if (v === 1'b1) begin
         chk(have && e.due == edge_n && q === e.data, {tag, "_rdata"}, q,
             have ? e.data : '0);
         if (have) begin
            if (which == 0) void'(q_rf.pop_front());
            else void'(q_wf.pop_front());
            last = e.data;
         end
      end else begin
         chk(v === 1'b0 && q === last, {tag, "_hold"}, q, last);
         chk(!(have && e.due <= edge_n), {tag, "_missing_vld"}, q, have ? e.data : '0);
         if (have && e.due <= edge_n) begin
            if (which == 0) void'(q_rf.pop_front());
            else void'(q_wf.pop_front());
         end
      end
      if (which == 0) last_rf = last;
      else last_wf = last;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         edge_n++;
         if (mon_en) begin
            mon_one(0, vld_rf, qout_rf, busy_rf);
            mon_one(1, vld_wf, qout_wf, busy_wf);
         end
      end
   end

   task automatic step(input bit r, input bit w, input logic [AW-1:0] aa, input logic [NB-1:0] be,
                       input logic [DW-1:0] d, input bit rd, input logic [AW-1:0] ab);
      int            e;
      logic [DW-1:0] old;
      @(negedge clk);
      rst    = r;
      wr_a   = w;
      addr_a = aa;
      be_a   = be;
      din_a  = d;
      rd_b   = rd;
      addr_b = ab;
      mon_en = 1'b1;
      e      = edge_n + 1;
      if (r) begin
         while (q_rf.size() > 0 && q_rf[$].due >= e) void'(q_rf.pop_back());
         while (q_wf.size() > 0 && q_wf[$].due >= e) void'(q_wf.pop_back());
         last_rf  = '0;
         last_wf  = '0;
         // The sweep zeroes everything before any request can be accepted.
         foreach (model_mem[i]) model_mem[i] = '0;
         clr_rem  = WORDS;
         exp_busy = 1'b1;
      end else begin
         if (!exp_busy && rd) begin
            old = model_mem[ab];
            q_rf.push_back('{due: e, data: old});
            q_wf.push_back('{due: e + 1, data: (w && aa == ab) ? merge(old, d, be) : old});
         end
         if (!exp_busy && w) model_mem[aa] = merge(model_mem[aa], d, be);
         if (clr_rem > 0) clr_rem--;
         exp_busy = (clr_rem > 0);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, '0, '0, '0, 0, '0);
   endtask

   task automatic rand_req();
      logic [AW-1:0] aa, ab;
      aa = AW'($urandom_range(0, 15));
      ab = ($urandom_range(0, 1) == 1) ? aa : AW'($urandom_range(0, 15));
      step(0, 1'($urandom_range(0, 1)), aa, NB'($urandom), $urandom, 1'($urandom_range(0, 1)), ab);
   endtask

   initial begin
      rst = 1'b1; wr_a = 1'b0; rd_b = 1'b0;
      addr_a = '0; addr_b = '0; be_a = '0; din_a = '0;

      // Reset, requests ignored during the sweep, then every word reads zero.
      step(1, 0, '0, '0, '0, 0, '0);
      for (int i = 0; i < WORDS; i++) rand_req();
      for (int i = 0; i < WORDS; i++) step(0, 0, '0, '0, '0, 1, AW'(i));
      idle(3);

      // Partial-lane merge.
      step(0, 1, 4'd3, 4'b1111, 32'hAABBCCDD, 0, '0);
      step(0, 1, 4'd3, 4'b0101, 32'h11223344, 0, '0);
      step(0, 0, '0, '0, '0, 1, 4'd3);
      idle(3);

      // Same-address read during write on a still-zero word.
      step(0, 1, 4'd5, 4'b0011, 32'hFFFFFFFF, 1, 4'd5);
      idle(3);

      // Back-to-back reads of freshly written words.
      for (int i = 0; i < 4; i++) step(0, 1, AW'(i), 4'b1111, $urandom, 0, '0);
      for (int i = 0; i < 4; i++) step(0, 0, '0, '0, '0, 1, AW'(i));
      idle(4);

      // Randomised traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) step(1, 0, '0, '0, '0, 0, '0);
         else rand_req();
      end
      idle(WORDS + 2);

      // Reset mid-clear, then a write attempt while busy.
      step(1, 0, '0, '0, '0, 0, '0);
      idle(7);
      step(1, 0, '0, '0, '0, 0, '0);
      step(0, 1, 4'd2, 4'b1111, 32'hDEADBEEF, 1, 4'd2);
      idle(WORDS + 2);
      step(0, 0, '0, '0, '0, 1, 4'd2);
      idle(4);

      // Read immediately followed by reset.
      step(0, 1, 4'd7, 4'b1111, 32'h5A5A1234, 0, '0);
      step(0, 0, '0, '0, '0, 1, 4'd7);
      step(1, 0, '0, '0, '0, 0, '0);
      idle(WORDS + 4);

      chk(q_rf.size() == 0, "rf_drain", DW'(q_rf.size()), '0);
      chk(q_wf.size() == 0, "wf_drain", DW'(q_wf.size()), '0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sdp_ram_be.md
SDP_RAM_BE -- requirements
Module: sdp_ram_be

Interface
REQ-001 The block SHALL have parameter DW, default 32, data width in bits; it must be a multiple of BW.
REQ-002 The block SHALL have parameter BW, default 8, byte-lane width; NB = DW/BW lanes.
REQ-003 The block SHALL have parameter WORDS, default 256, depth ≥ 2; AW = $clog2(WORDS).
REQ-004 The block SHALL have parameter RDW_MODE, default RDW_READ_FIRST, same-address read-during-write policy: RDW_READ_FIRST or RDW_WRITE_FIRST.
REQ-005 The block SHALL have parameter OUT_REG, default 0; 1 adds one output pipeline register.
REQ-006 The block SHALL have parameter CLR_ON_RST, default 1; 1 zero-fills the array after reset.
REQ-007 The block SHALL have port clk  in  1  sole clock, rising edge.
REQ-008 The block SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-009 The block SHALL have port addr_a  in  AW  write address.
REQ-010 The block SHALL have port wr_a  in  1  write request.
REQ-011 The block SHALL have port be_a  in  NB  byte-lane write enables; bit i covers din_a[i*BW +: BW].
REQ-012 The block SHALL have port din_a  in  DW  write data.
REQ-013 The block SHALL have port addr_b  in  AW  read address.
REQ-014 The block SHALL have port rd_b  in  1  read request.
REQ-015 The block SHALL have port qout_b  out  DW  read data.
REQ-016 The block SHALL have port vld_b  out  1  qout_b carries the data of a completed read this cycle.
REQ-017 The block SHALL have port busy  out  1  clear in progress; requests are ignored.

Function
REQ-018 The block SHALL write, on a write (wr_a & !busy), only the lanes of ram[addr_a] with be_a[i]=1; other lanes are unchanged; be_a=0 is a no-op.
REQ-019 The block SHALL capture ram[addr_b] on a read (rd_b & !busy); qout_b/vld_b appear 1 cycle later (OUT_REG=0) or 2 cycles later (OUT_REG=1); back-to-back reads give one result per cycle.
REQ-020 The block SHALL hold qout_b at its last value with vld_b=0 in any cycle with no completing read.
REQ-021 The block SHALL return the pre-write word on a same-cycle read and write to one address when RDW_MODE=RDW_READ_FIRST.
REQ-022 The block SHALL return the merged word (enabled lanes from din_a, others old) on a same-cycle read and write to one address when RDW_MODE=RDW_WRITE_FIRST.
REQ-023 The block SHALL apply no RDW_MODE handling to different addresses; the read returns the stored word.
REQ-024 The block SHALL implement a clear FSM with states IDLE and CLEAR.
REQ-025 The block SHALL, while rst=1, force state CLEAR with cnt=0 if CLR_ON_RST=1, else IDLE.
REQ-026 The block SHALL, in CLEAR, write all-zero to ram[cnt] each cycle with busy=1; after cnt=WORDS-1, cnt wraps to 0 and the state goes to IDLE.
REQ-027 The block SHALL keep busy high for exactly WORDS cycles after rst deasserts; the first accepted request is in cycle WORDS+1.
REQ-028 The block SHALL ignore wr_a and rd_b while busy=1; they produce no write, no read and no vld_b.
REQ-029 The block SHALL restart the clear at cnt=0 when rst is asserted mid-clear.
REQ-030 The block SHALL drop in-flight reads when rst is asserted mid-read; no vld_b pulse follows reset.

Reset
REQ-031 The block SHALL set qout_b=0, vld_b=0 and all pipeline valids=0 in the cycle after rst is sampled high.
REQ-032 The block SHALL drive busy=1 during and after rst when CLR_ON_RST=1, else 0.
REQ-033 The block SHALL reset no array contents other than by the CLEAR sweep.

Structure
REQ-034 The block SHALL take rdw_mode_e (RDW_READ_FIRST, RDW_WRITE_FIRST) and clr_state_e (IDLE, CLEAR) from package sdp_ram_pkg.
REQ-035 The block SHALL place the clear FSM and counter in sub-module sdp_ram_clr_ctrl (outputs busy, clr_we, clr_addr).
REQ-036 The block SHALL keep array, lane-merge and read pipeline in sdp_ram_be.

Verification
REQ-037 The bench SHALL cover: rst 1 cycle, CLR_ON_RST=1, WORDS=16 -> busy=1 for exactly 16 cycles; every read then returns 0.
REQ-038 The bench SHALL cover: write 0xAABBCCDD to addr 3 with be_a=4'b1111, then be_a=4'b0101 with din 0x11223344 -> read addr 3 gives 0xAA22CC44.
REQ-039 The bench SHALL cover: addr 5 holds 0x0, same-cycle write 0xFFFFFFFF (be_a=4'b0011) and read of addr 5 -> 0x00000000 under read-first; 0x0000FFFF under write-first.
REQ-040 The bench SHALL cover: OUT_REG=1, reads on 4 consecutive cycles to addrs 0..3 -> vld_b high for 4 cycles starting 2 cycles after the first read, data in order.
REQ-041 The bench SHALL cover: rst at clear cycle 7, then write addr 2 while busy -> busy lasts WORDS more cycles; addr 2 reads 0.
REQ-042 The bench SHALL cover: a read issued, then rst the next cycle -> no vld_b; qout_b=0.
